// File: rtl/ender_clock_pkg.sv
// ender_clock_pkg: shared widths, segment constants and digit positions for the clock display path
package ender_clock_pkg;
  localparam int NUM_DIGITS = 6;
  localparam int DIGIT_W = 4;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  typedef enum logic [2:0] {SEC_U, SEC_T, MIN_U, MIN_T, HOUR_U, HOUR_T} digit_e;
  function automatic logic [DIGIT_W-1:0] digit_of(input logic [NUM_DIGITS*DIGIT_W-1:0] d, input logic [2:0] i);
    return d[{i, 2'b00} +: DIGIT_W];
  endfunction
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: BCD nibble to active-high a..g pattern, non-decimal codes shown as a dash
module bcd_to_seg7
  import ender_clock_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0: o_seg = 7'h3F;
      4'd1: o_seg = 7'h06;
      4'd2: o_seg = 7'h5B;
      4'd3: o_seg = 7'h4F;
      4'd4: o_seg = 7'h66;
      4'd5: o_seg = 7'h6D;
      4'd6: o_seg = 7'h7D;
      4'd7: o_seg = 7'h07;
      4'd8: o_seg = 7'h7F;
      4'd9: o_seg = 7'h6F;
      default: o_seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/clock_display_scanner.sv
// clock_display_scanner: time-multiplexed six-digit 7-segment driver with blanking, blink and frame-atomic updates
module clock_display_scanner
  import ender_clock_pkg::*;
#(
  parameter int SCAN_DIV = 10000,
  parameter int BLANK_CYC = 500,
  parameter int LZ_SUPPRESS = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_bcd,
  input  logic                          digits_valid,
  input  logic [NUM_DIGITS-1:0]         blink_mask,
  input  logic                          blink_tick,
  input  logic [NUM_DIGITS-1:0]         dp_mask,
  output logic [6:0]                    seg_o,
  output logic                          dp_o,
  output logic [NUM_DIGITS-1:0]         dig_o,
  output logic                          frame_start
);
  localparam int PW = $clog2(SCAN_DIV);
  logic [PW-1:0] r_pre;
  logic [2:0] r_idx;
  logic [NUM_DIGITS*DIGIT_W-1:0] r_pend, r_disp;
  logic r_pflag, r_phase;
  logic [6:0] r_seg;
  logic r_dp, r_fs;
  logic [NUM_DIGITS-1:0] r_dig;
  logic w_slot_end, w_last, w_wrap, w_blink, w_lz;
  logic [DIGIT_W-1:0] w_nib;
  logic [6:0] w_raw, w_seg;
  logic w_dp;
  logic [NUM_DIGITS-1:0] w_dig;
  bcd_to_seg7 u_dec (.i_bcd(w_nib), .o_seg(w_raw));
  always_comb begin
    w_slot_end = r_pre == PW'(SCAN_DIV - 1);
    w_last = r_idx == HOUR_T;
    w_wrap = ena && w_slot_end && w_last;
    w_nib = digit_of(r_disp, r_idx);
    w_blink = blink_mask[r_idx] & r_phase;
    w_lz = (LZ_SUPPRESS != 0) && w_last && (w_nib == '0);
    w_seg = (w_blink || w_lz) ? SEG_BLANK : w_raw;
    w_dp = dp_mask[r_idx] & ~w_blink;
    w_dig = (r_pre < PW'(BLANK_CYC)) ? '0 : NUM_DIGITS'(1) << r_idx;
  end
  // the display register only changes on the frame wrap so a frame never mixes two times
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_idx <= SEC_U;
      r_pend <= '0;
      r_disp <= '0;
      r_pflag <= 1'b0;
      r_phase <= 1'b0;
      r_seg <= '0;
      r_dp <= 1'b0;
      r_dig <= '0;
      r_fs <= 1'b0;
    end else begin
      if (digits_valid) r_pend <= digits_bcd;
      r_pflag <= w_wrap ? 1'b0 : (r_pflag | digits_valid);
      if (w_wrap && (digits_valid || r_pflag)) r_disp <= digits_valid ? digits_bcd : r_pend;
      if (ena) begin
        r_pre <= w_slot_end ? '0 : r_pre + 1'b1;
        if (w_slot_end) r_idx <= w_last ? SEC_U : r_idx + 3'd1;
        r_phase <= r_phase ^ blink_tick;
        r_seg <= w_seg;
        r_dp <= w_dp;
        r_dig <= w_dig;
        r_fs <= (r_pre == '0) && (r_idx == SEC_U);
      end else begin
        r_seg <= '0;
        r_dp <= 1'b0;
        r_dig <= '0;
        r_fs <= 1'b0;
      end
    end
  end
  assign seg_o = r_seg;
  assign dp_o = r_dp;
  assign dig_o = r_dig;
  assign frame_start = r_fs;
endmodule

// File: tb/tb_clock_display_scanner.sv
// tb_clock_display_scanner: directed cycle-accurate vectors for the display scanner with a 4-cycle slot
module tb_clock_display_scanner;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1, digits_valid = 1'b0, blink_tick = 1'b0;
  logic [23:0] digits_bcd = '0;
  logic [5:0] blink_mask = '0, dp_mask = '0;
  logic [6:0] seg_o;
  logic dp_o, frame_start;
  logic [5:0] dig_o;
  int errors = 0, checks = 0;
  typedef struct {
    string nm;
    int cyc;
    logic en, vl;
    logic [23:0] bcd;
    logic [5:0] bm, dm;
    logic tk;
    logic [5:0] dig;
    logic [6:0] seg;
    logic dp, fs;
  } vec_t;
  vec_t tbl[$];
  clock_display_scanner #(.SCAN_DIV(4), .BLANK_CYC(1), .LZ_SUPPRESS(1)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .digits_bcd(digits_bcd), .digits_valid(digits_valid),
    .blink_mask(blink_mask), .blink_tick(blink_tick), .dp_mask(dp_mask),
    .seg_o(seg_o), .dp_o(dp_o), .dig_o(dig_o), .frame_start(frame_start)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_all(input string nm, input logic [5:0] dig, input logic [6:0] seg, input logic dp, input logic fs);
    chk({nm, ".dig"}, 32'(dig_o), 32'(dig));
    chk({nm, ".seg"}, 32'(seg_o), 32'(seg));
    chk({nm, ".dp"}, 32'(dp_o), 32'(dp));
    chk({nm, ".fs"}, 32'(frame_start), 32'(fs));
  endtask
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      digits_valid = 1'b0;
      blink_tick = 1'b0;
    end
  endtask
  initial begin
    tbl.push_back('{"a_start",    1, 1, 1, 24'h123456, 6'h00, 6'h00, 0, 6'b000000, 7'h3F, 0, 1});
    tbl.push_back('{"a_d0",       1, 1, 0, 24'h123456, 6'h00, 6'h00, 0, 6'b000001, 7'h3F, 0, 0});
    tbl.push_back('{"a_d5_lz",   22, 1, 0, 24'h123456, 6'h00, 6'h00, 0, 6'b100000, 7'h00, 0, 0});
    tbl.push_back('{"a_f2",       1, 1, 0, 24'h123456, 6'h00, 6'h00, 0, 6'b000000, 7'h7D, 0, 1});
    tbl.push_back('{"a_f2d0",     1, 1, 0, 24'h123456, 6'h00, 6'h00, 0, 6'b000001, 7'h7D, 0, 0});
    tbl.push_back('{"a_f2d1",     4, 1, 0, 24'h123456, 6'h00, 6'h00, 0, 6'b000010, 7'h6D, 0, 0});
    tbl.push_back('{"a_f2d2",     4, 1, 0, 24'h123456, 6'h00, 6'h00, 0, 6'b000100, 7'h66, 0, 0});
    tbl.push_back('{"a_f2d3",     4, 1, 0, 24'h123456, 6'h00, 6'h00, 0, 6'b001000, 7'h4F, 0, 0});
    tbl.push_back('{"a_f2d4",     4, 1, 0, 24'h123456, 6'h00, 6'h00, 0, 6'b010000, 7'h5B, 0, 0});
    tbl.push_back('{"a_f2d5",     4, 1, 0, 24'h123456, 6'h00, 6'h00, 0, 6'b100000, 7'h06, 0, 0});
    tbl.push_back('{"a_f3",       3, 1, 0, 24'h123456, 6'h00, 6'h00, 0, 6'b000000, 7'h7D, 0, 1});
    tbl.push_back('{"b_idx2",     8, 1, 0, 24'h000000, 6'h00, 6'h00, 0, 6'b000000, 7'h66, 0, 0});
    tbl.push_back('{"b_strobe",   1, 1, 1, 24'h000000, 6'h00, 6'h00, 0, 6'b000100, 7'h66, 0, 0});
    tbl.push_back('{"b_old_d3",   4, 1, 0, 24'h000000, 6'h00, 6'h00, 0, 6'b001000, 7'h4F, 0, 0});
    tbl.push_back('{"b_old_d5",   8, 1, 0, 24'h000000, 6'h00, 6'h00, 0, 6'b100000, 7'h06, 0, 0});
    tbl.push_back('{"b_new_f",    3, 1, 0, 24'h000000, 6'h00, 6'h00, 0, 6'b000000, 7'h3F, 0, 1});
    tbl.push_back('{"b_new_d0",   1, 1, 0, 24'h000000, 6'h00, 6'h00, 0, 6'b000001, 7'h3F, 0, 0});
    tbl.push_back('{"b_lz_d5",   20, 1, 0, 24'h000000, 6'h00, 6'h00, 0, 6'b100000, 7'h00, 0, 0});
    tbl.push_back('{"c_pre",      1, 1, 0, 24'h235959, 6'h00, 6'h00, 0, 6'b100000, 7'h00, 0, 0});
    tbl.push_back('{"c_wrap",     1, 1, 1, 24'h235959, 6'h00, 6'h00, 0, 6'b100000, 7'h00, 0, 0});
    tbl.push_back('{"c_f",        1, 1, 0, 24'h235959, 6'h00, 6'h00, 0, 6'b000000, 7'h6F, 0, 1});
    tbl.push_back('{"c_d0",       1, 1, 0, 24'h235959, 6'h00, 6'h00, 0, 6'b000001, 7'h6F, 0, 0});
    tbl.push_back('{"c_d5",      20, 1, 0, 24'h235959, 6'h00, 6'h00, 0, 6'b100000, 7'h5B, 0, 0});
    tbl.push_back('{"d_blk_f",    3, 1, 0, 24'h235959, 6'h03, 6'h04, 1, 6'b000000, 7'h00, 0, 1});
    tbl.push_back('{"d_blk_d0",   1, 1, 0, 24'h235959, 6'h03, 6'h04, 0, 6'b000001, 7'h00, 0, 0});
    tbl.push_back('{"d_blk_d1",   4, 1, 0, 24'h235959, 6'h03, 6'h04, 0, 6'b000010, 7'h00, 0, 0});
    tbl.push_back('{"d_dp_d2",    4, 1, 0, 24'h235959, 6'h03, 6'h04, 0, 6'b000100, 7'h6F, 1, 0});
    tbl.push_back('{"d_d3",       4, 1, 0, 24'h235959, 6'h03, 6'h04, 0, 6'b001000, 7'h6D, 0, 0});
    tbl.push_back('{"d_unblk_f", 11, 1, 0, 24'h235959, 6'h03, 6'h04, 1, 6'b000000, 7'h6F, 0, 1});
    tbl.push_back('{"d_unblk_d1", 5, 1, 0, 24'h235959, 6'h03, 6'h04, 0, 6'b000010, 7'h6D, 0, 0});
    tbl.push_back('{"e_strobe",   1, 1, 1, 24'h23C959, 6'h00, 6'h00, 0, 6'b000010, 7'h6D, 0, 0});
    tbl.push_back('{"e_d0",      20, 1, 0, 24'h23C959, 6'h00, 6'h00, 0, 6'b000001, 7'h6F, 0, 0});
    tbl.push_back('{"e_dash_d3", 12, 1, 0, 24'h23C959, 6'h00, 6'h00, 0, 6'b001000, 7'h40, 0, 0});
    tbl.push_back('{"f_off1",     1, 0, 0, 24'h23C959, 6'h00, 6'h00, 0, 6'b000000, 7'h00, 0, 0});
    tbl.push_back('{"f_off10",    9, 0, 0, 24'h23C959, 6'h00, 6'h00, 0, 6'b000000, 7'h00, 0, 0});
    tbl.push_back('{"f_resume",   1, 1, 0, 24'h23C959, 6'h00, 6'h00, 0, 6'b001000, 7'h40, 0, 0});
    tbl.push_back('{"f_next",     1, 1, 0, 24'h23C959, 6'h00, 6'h00, 0, 6'b000000, 7'h4F, 0, 0});
    tick(3);
    chk_all("reset", 6'b0, 7'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    foreach (tbl[n]) begin
      ena = tbl[n].en;
      digits_valid = tbl[n].vl;
      digits_bcd = tbl[n].bcd;
      blink_mask = tbl[n].bm;
      dp_mask = tbl[n].dm;
      blink_tick = tbl[n].tk;
      tick(tbl[n].cyc);
      chk_all(tbl[n].nm, tbl[n].dig, tbl[n].seg, tbl[n].dp, tbl[n].fs);
    end
    // reset mid-slot must beat a concurrent strobe and blink toggle
    tick(1);
    rst_n = 1'b0;
    digits_valid = 1'b1;
    digits_bcd = 24'h123456;
    blink_tick = 1'b1;
    blink_mask = 6'b000001;
    dp_mask = 6'b000010;
    tick(1);
    chk_all("rst_mid", 6'b0, 7'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick(1);
    chk_all("rst_rel", 6'b0, 7'h3F, 1'b0, 1'b1);
    tick(1);
    chk_all("rst_d0", 6'b000001, 7'h3F, 1'b0, 1'b0);
    tick(23);
    chk_all("rst_f2", 6'b000000, 7'h3F, 1'b0, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/clock_display_scanner.md
Name: clock_display_scanner

Overview:
- Downstream stage of the tt_um_ender_clock time-keeping core; consumes its six BCD digits (HH:MM:SS) and drives a multiplexed common-cathode 7-segment display.
- Time-division scans one digit per slot, with anti-ghost blanking, tear-free frame updates, blink and decimal-point masks, and hour-tens leading-zero suppression.
- Segments map to uo_out; digit selects map to uio_out.

Parameters:
- SCAN_DIV, 10000: clk cycles per digit slot; legal range ≥ 2.
- BLANK_CYC, 500: cycles at the start of each slot with all digit selects off; must be < SCAN_DIV.
- LZ_SUPPRESS, 1: 1 blanks digit 5 when its value is 0.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- ena  in  1  run enable; 0 freezes all state and drives outputs off.
- digits_bcd  in  24  digit i = bits [4i+3:4i]; digit 0 = seconds units, digit 5 = hours tens.
- digits_valid  in  1  single-cycle strobe: digits_bcd holds a new time.
- blink_mask  in  6  1 = digit blinks (set-mode indication).
- blink_tick  in  1  single-cycle pulse; toggles the blink phase.
- dp_mask  in  6  1 = decimal point lit on that digit.
- seg_o  out  7  segments a..g, active high; bit0 = a, bit6 = g.
- dp_o  out  1  decimal point, active high.
- dig_o  out  6  one-hot digit select, active high.
- frame_start  out  1  one-cycle pulse when slot 0 begins.

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - Registers: prescaler = 0, digit index = 0, pending = 0, display = 0, pend_flag = 0, blink_phase = 0.
  - Outputs: seg_o = 0, dp_o = 0, dig_o = 0, frame_start = 0.
  - Reset dominates ena and all strobes, including mid-slot.
- Prescaler: counts 0..SCAN_DIV-1 while ena = 1.
  - At SCAN_DIV-1 it wraps to 0 and the digit index advances 0→1→…→5→0.
- Snapshot:
  - digits_valid = 1 loads the pending register with digits_bcd and sets pend_flag.
  - At the frame wrap (index 5→0) the display register is updated: display ← digits_valid ? digits_bcd : pending (only if valid or pend_flag), and pend_flag is cleared.
  - A valid strobe on the wrap cycle is used directly; no tearing within a frame.
- Decode (per current index, via bcd_to_seg7):
  - Values 0–9 use standard patterns. 0 = 0x3F, 1 = 0x06, 8 = 0x7F.
  - Values A–F show a dash (0x40).
  - Segments are forced to 0 when blink_mask[idx] & blink_phase = 1.
  - Segments are forced to 0 when LZ_SUPPRESS and idx = 5 and the value is 0.
  - dp_o = dp_mask[idx], also forced 0 when the digit is blink-blanked; never forced 0 by leading-zero suppression.
- Blanking: dig_o = 0 while prescaler < BLANK_CYC; otherwise dig_o = 1 << idx.
- Latency: all outputs are registered, 1 cycle after the prescaler/index state they reflect.
  - frame_start = 1 in the cycle after the state becomes idx = 0, prescaler = 0.
- blink_tick toggles blink_phase at any time, independent of scan position.
- ena = 0:
  - Prescaler, index and blink_phase hold.
  - Outputs are registered to 0 next cycle.
  - digits_valid is still captured into pending.
  - Scanning resumes from the held position when ena returns to 1.

Decomposition:
- Package ender_clock_pkg:
  - NUM_DIGITS = 6, DIGIT_W = 4.
  - SEG_DASH = 7'h40, SEG_BLANK = 7'h00.
  - Digit index constants (SEC_U = 0 … HOUR_T = 5).
- Sub-module bcd_to_seg7: 4-bit in, 7-bit out, purely combinational.
- Top RTL: prescaler, index, snapshot/pending, blink, and the output registers.

Test Plan (SCAN_DIV = 4, BLANK_CYC = 1):
- Reset then release, digits_valid with 24'h123456 → after one frame, dig_o sequence is 000001, 000010, …, 100000 (3 cycles each, preceded by 1 cycle of 000000); seg_o on digit 0 = 0x7D (6), on digit 5 = 0x06 (1); frame_start pulses every 24 cycles.
- digits_valid with 24'h000000 mid-frame at idx 2 → remaining slots of the current frame still show the old value; the next frame shows 0x3F on digits 0–4 and seg_o = 0 on digit 5 (LZ_SUPPRESS = 1), with dig_o[5] still asserted.
- digits_valid on the exact wrap cycle with 24'h235959 → the new frame shows digit 0 = 0x6F (9) with no intervening old frame.
- blink_mask = 6'b000011, dp_mask = 6'b000100, one blink_tick → digits 0–1 show seg_o = 0 and dp_o = 0; dp_o = 1 only on digit 2; a second tick restores digits 0–1.
- digits_bcd nibble 4'hC on digit 3 → seg_o = 0x40 during slot 3.
- ena low at idx 3 for 10 cycles → outputs 0 from the next cycle, index holds at 3; after ena returns high, dig_o = 001000 resumes. rst_n low mid-slot → all outputs 0 at the next edge and idx = 0.
